// File: rtl/dex_pkg.sv
// Shared constants, instruction field slices and the bubble value for the ID/EX register.
// Imported by the interface, the bypass mux and the pipeline register.
package dex_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int          REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Control-side fields that define a bubble; data fields are simply zeroed.
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic        rd_wren;
    logic        is_load;
  } ctl_tag_t;

  function automatic reg_addr_t rd_of(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic reg_addr_t rs1_of(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic reg_addr_t rs2_of(input logic [31:0] inst);
    return inst[24:20];
  endfunction

  function automatic ctl_tag_t bubble_tag();
    return '{valid: 1'b0, inst: NOP_INST, rd_wren: 1'b0, is_load: 1'b0};
  endfunction

endpackage

// File: rtl/decode_ex_reg_if.sv
// Decode-to-execute bundle: decode-side inputs, bypass sources, and the registered EX entry.
// master = decode/pipeline control side, slave = the ID/EX register.
interface decode_ex_reg_if
  import dex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) ();

  logic              i_dex_valid;
  logic [XLEN-1:0]   i_dex_pc;
  logic [31:0]       i_dex_inst;
  logic [XLEN-1:0]   i_dex_rs1_data;
  logic [XLEN-1:0]   i_dex_rs2_data;
  logic [XLEN-1:0]   i_dex_imm;
  logic [CTRL_W-1:0] i_dex_ctrl;
  logic              i_dex_rd_wren;
  logic              i_dex_is_load;
  logic              i_dex_uses_rs1;
  logic              i_dex_uses_rs2;
  logic              i_dex_flush;
  logic              i_dex_hold;
  logic              i_dex_mem_wren;
  reg_addr_t         i_dex_mem_addr;
  logic [XLEN-1:0]   i_dex_mem_data;
  logic              i_dex_wb_wren;
  reg_addr_t         i_dex_wb_addr;
  logic [XLEN-1:0]   i_dex_wb_data;

  logic              o_dex_valid;
  logic [XLEN-1:0]   o_dex_pc;
  logic [31:0]       o_dex_inst;
  logic [XLEN-1:0]   o_dex_rs1_data;
  logic [XLEN-1:0]   o_dex_rs2_data;
  logic [XLEN-1:0]   o_dex_imm;
  logic [CTRL_W-1:0] o_dex_ctrl;
  logic              o_dex_rd_wren;
  logic              o_dex_is_load;
  logic              o_dex_load_use;
  logic              o_dex_stall_up;
  logic [CNT_W-1:0]  o_dex_stall_cnt;
  logic [CNT_W-1:0]  o_dex_flush_cnt;

  modport master (
    output i_dex_valid, i_dex_pc, i_dex_inst, i_dex_rs1_data, i_dex_rs2_data, i_dex_imm,
           i_dex_ctrl, i_dex_rd_wren, i_dex_is_load, i_dex_uses_rs1, i_dex_uses_rs2,
           i_dex_flush, i_dex_hold, i_dex_mem_wren, i_dex_mem_addr, i_dex_mem_data,
           i_dex_wb_wren, i_dex_wb_addr, i_dex_wb_data,
    input  o_dex_valid, o_dex_pc, o_dex_inst, o_dex_rs1_data, o_dex_rs2_data, o_dex_imm,
           o_dex_ctrl, o_dex_rd_wren, o_dex_is_load, o_dex_load_use, o_dex_stall_up,
           o_dex_stall_cnt, o_dex_flush_cnt
  );

  modport slave (
    input  i_dex_valid, i_dex_pc, i_dex_inst, i_dex_rs1_data, i_dex_rs2_data, i_dex_imm,
           i_dex_ctrl, i_dex_rd_wren, i_dex_is_load, i_dex_uses_rs1, i_dex_uses_rs2,
           i_dex_flush, i_dex_hold, i_dex_mem_wren, i_dex_mem_addr, i_dex_mem_data,
           i_dex_wb_wren, i_dex_wb_addr, i_dex_wb_data,
    output o_dex_valid, o_dex_pc, o_dex_inst, o_dex_rs1_data, o_dex_rs2_data, o_dex_imm,
           o_dex_ctrl, o_dex_rd_wren, o_dex_is_load, o_dex_load_use, o_dex_stall_up,
           o_dex_stall_cnt, o_dex_flush_cnt
  );

endinterface

// File: rtl/dex_fwd_mux.sv
// Operand bypass: x0 -> 0, else MEM (younger) over WB over regfile; purely combinational.
// With FWD_EN=0 only the x0 guard remains in front of the regfile data.
module dex_fwd_mux
  import dex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  reg_addr_t       src_addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            mem_wren,
  input  reg_addr_t       mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wren,
  input  reg_addr_t       wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd_data
);

  always_comb begin
    fwd_data = rf_data;
    if (src_addr == '0) begin
      fwd_data = '0;
    end else if (FWD_EN && mem_wren && (mem_addr == src_addr)) begin
      fwd_data = mem_data;
    end else if (FWD_EN && wb_wren && (wb_addr == src_addr)) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/decode_ex_reg.sv
// ID/EX pipeline register with operand bypass, load-use bubbles, flush and event counters; 1-cycle latency.
// Downstream hold freezes the entry; load-use and hold both stall upstream through o_dex_stall_up.
module decode_ex_reg
  import dex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input logic           i_dex_clk,
  input logic           i_dex_reset,
  decode_ex_reg_if.slave dex
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              rd_wren_q, rd_wren_d;
  logic              is_load_q, is_load_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  reg_addr_t         rs1_addr, rs2_addr, rd_ex;
  logic [XLEN-1:0]   rs1_fwd, rs2_fwd;
  logic              load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign rs1_addr = rs1_of(dex.i_dex_inst);
  assign rs2_addr = rs2_of(dex.i_dex_inst);
  assign rd_ex    = rd_of(inst_q);

  dex_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .src_addr (rs1_addr),
    .rf_data  (dex.i_dex_rs1_data),
    .mem_wren (dex.i_dex_mem_wren),
    .mem_addr (dex.i_dex_mem_addr),
    .mem_data (dex.i_dex_mem_data),
    .wb_wren  (dex.i_dex_wb_wren),
    .wb_addr  (dex.i_dex_wb_addr),
    .wb_data  (dex.i_dex_wb_data),
    .fwd_data (rs1_fwd)
  );

  dex_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .src_addr (rs2_addr),
    .rf_data  (dex.i_dex_rs2_data),
    .mem_wren (dex.i_dex_mem_wren),
    .mem_addr (dex.i_dex_mem_addr),
    .mem_data (dex.i_dex_mem_data),
    .wb_wren  (dex.i_dex_wb_wren),
    .wb_addr  (dex.i_dex_wb_addr),
    .wb_data  (dex.i_dex_wb_data),
    .fwd_data (rs2_fwd)
  );

  // A load in EX cannot forward its result to the instruction right behind it.
  assign load_use = valid_q && is_load_q && rd_wren_q && (rd_ex != '0) && dex.i_dex_valid &&
                    ((dex.i_dex_uses_rs1 && (rs1_addr == rd_ex)) ||
                     (dex.i_dex_uses_rs2 && (rs2_addr == rd_ex)));

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    rd_wren_d   = rd_wren_q;
    is_load_d   = is_load_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (dex.i_dex_flush || (!dex.i_dex_hold && load_use)) begin
      {valid_d, inst_d, rd_wren_d, is_load_d} = bubble_tag();
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      ctrl_d     = '0;
      if (dex.i_dex_flush) begin
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
    end else if (!dex.i_dex_hold) begin
      valid_d    = dex.i_dex_valid;
      pc_d       = dex.i_dex_pc;
      inst_d     = dex.i_dex_inst;
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
      imm_d      = dex.i_dex_imm;
      ctrl_d     = dex.i_dex_valid ? dex.i_dex_ctrl : '0;
      rd_wren_d  = dex.i_dex_valid && dex.i_dex_rd_wren;
      is_load_d  = dex.i_dex_is_load;
    end
  end

  always_ff @(posedge i_dex_clk) begin
    if (i_dex_reset) begin
      {valid_q, inst_q, rd_wren_q, is_load_q} <= bubble_tag();
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      rd_wren_q   <= rd_wren_d;
      is_load_q   <= is_load_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign dex.o_dex_valid     = valid_q;
  assign dex.o_dex_pc        = pc_q;
  assign dex.o_dex_inst      = inst_q;
  assign dex.o_dex_rs1_data  = rs1_data_q;
  assign dex.o_dex_rs2_data  = rs2_data_q;
  assign dex.o_dex_imm       = imm_q;
  assign dex.o_dex_ctrl      = ctrl_q;
  assign dex.o_dex_rd_wren   = rd_wren_q;
  assign dex.o_dex_is_load   = is_load_q;
  assign dex.o_dex_load_use  = load_use;
  assign dex.o_dex_stall_up  = load_use || dex.i_dex_hold;
  assign dex.o_dex_stall_cnt = stall_cnt_q;
  assign dex.o_dex_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_decode_ex_reg.sv
// Directed bench for decode_ex_reg; counters use CNT_W=2 so saturation is reachable quickly.
module tb_decode_ex_reg;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADDI    = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] LW_X5   = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] ADD_655 = 32'h0072_8333; // add x6,x5,x7
  localparam logic [31:0] ADD_432 = 32'h0021_8233; // add x4,x3,x2
  localparam logic [31:0] ADD_400 = 32'h0000_0233; // add x4,x0,x0

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decode_ex_reg_if #(.XLEN(32), .CTRL_W(16), .CNT_W(2)) dif ();

  decode_ex_reg #(.XLEN(32), .CTRL_W(16), .FWD_EN(1'b1), .CNT_W(2)) dut (
    .i_dex_clk   (clk),
    .i_dex_reset (rst),
    .dex         (dif.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    dif.i_dex_valid = 0; dif.i_dex_pc = '0; dif.i_dex_inst = NOP;
    dif.i_dex_rs1_data = '0; dif.i_dex_rs2_data = '0; dif.i_dex_imm = '0;
    dif.i_dex_ctrl = '0; dif.i_dex_rd_wren = 0; dif.i_dex_is_load = 0;
    dif.i_dex_uses_rs1 = 0; dif.i_dex_uses_rs2 = 0; dif.i_dex_flush = 0; dif.i_dex_hold = 0;
    dif.i_dex_mem_wren = 0; dif.i_dex_mem_addr = '0; dif.i_dex_mem_data = '0;
    dif.i_dex_wb_wren = 0; dif.i_dex_wb_addr = '0; dif.i_dex_wb_data = '0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    tick();
    n_vec++; if (dif.o_dex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", dif.o_dex_valid); end
    n_vec++; if (dif.o_dex_inst !== NOP) begin n_err++; $display("FAIL reset_inst: got %h want %h", dif.o_dex_inst, NOP); end
    rst = 0;
    dif.i_dex_valid = 1; dif.i_dex_pc = 32'h40; dif.i_dex_inst = ADDI; dif.i_dex_rd_wren = 1;
    dif.i_dex_imm = 32'h5; dif.i_dex_ctrl = 16'h0011; dif.i_dex_uses_rs1 = 1;
    tick();
    n_vec++; if (dif.o_dex_pc !== 32'h40) begin n_err++; $display("FAIL capture_pc: got %h want 40", dif.o_dex_pc); end
    n_vec++; if (dif.o_dex_inst !== ADDI) begin n_err++; $display("FAIL capture_inst: got %h want %h", dif.o_dex_inst, ADDI); end
    // reset also beats a simultaneous flush
    rst = 1; dif.i_dex_flush = 1;
    tick();
    rst = 0; set_idle();
    n_vec++; if (dif.o_dex_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", dif.o_dex_valid); end
    n_vec++; if (dif.o_dex_inst !== NOP) begin n_err++; $display("FAIL midreset_inst: got %h want %h", dif.o_dex_inst, NOP); end
    n_vec++; if (dif.o_dex_pc !== 32'h0) begin n_err++; $display("FAIL midreset_pc: got %h want 0", dif.o_dex_pc); end
    n_vec++; if (dif.o_dex_flush_cnt !== 2'd0) begin n_err++; $display("FAIL midreset_flush_cnt: got %0d want 0", dif.o_dex_flush_cnt); end
    n_vec++; if (dif.o_dex_stall_cnt !== 2'd0) begin n_err++; $display("FAIL midreset_stall_cnt: got %0d want 0", dif.o_dex_stall_cnt); end
  endtask

  task automatic test_bypass();
    set_idle();
    dif.i_dex_valid = 1; dif.i_dex_inst = ADD_432; dif.i_dex_uses_rs1 = 1; dif.i_dex_uses_rs2 = 1;
    dif.i_dex_rs1_data = 32'h1111; dif.i_dex_rs2_data = 32'h2222;
    dif.i_dex_mem_wren = 1; dif.i_dex_mem_addr = 5'd3; dif.i_dex_mem_data = 32'hAAAA;
    dif.i_dex_wb_wren = 1; dif.i_dex_wb_addr = 5'd3; dif.i_dex_wb_data = 32'hBBBB;
    tick();
    n_vec++; if (dif.o_dex_rs1_data !== 32'hAAAA) begin n_err++; $display("FAIL byp_mem_prio: got %h want AAAA", dif.o_dex_rs1_data); end
    n_vec++; if (dif.o_dex_rs2_data !== 32'h2222) begin n_err++; $display("FAIL byp_rs2_rf: got %h want 2222", dif.o_dex_rs2_data); end
    dif.i_dex_mem_wren = 0;
    tick();
    n_vec++; if (dif.o_dex_rs1_data !== 32'hBBBB) begin n_err++; $display("FAIL byp_wb: got %h want BBBB", dif.o_dex_rs1_data); end
    dif.i_dex_mem_wren = 1; dif.i_dex_mem_addr = 5'd2; dif.i_dex_mem_data = 32'hCCCC; dif.i_dex_wb_wren = 0;
    tick();
    n_vec++; if (dif.o_dex_rs1_data !== 32'h1111) begin n_err++; $display("FAIL byp_rf: got %h want 1111", dif.o_dex_rs1_data); end
    n_vec++; if (dif.o_dex_rs2_data !== 32'hCCCC) begin n_err++; $display("FAIL byp_rs2_mem: got %h want CCCC", dif.o_dex_rs2_data); end
    dif.i_dex_inst = ADD_400;
    dif.i_dex_mem_wren = 1; dif.i_dex_mem_addr = 5'd0; dif.i_dex_wb_wren = 1; dif.i_dex_wb_addr = 5'd0;
    tick();
    n_vec++; if (dif.o_dex_rs1_data !== 32'h0) begin n_err++; $display("FAIL byp_x0_rs1: got %h want 0", dif.o_dex_rs1_data); end
    n_vec++; if (dif.o_dex_rs2_data !== 32'h0) begin n_err++; $display("FAIL byp_x0_rs2: got %h want 0", dif.o_dex_rs2_data); end
  endtask

  task automatic test_invalid_capture();
    set_idle();
    dif.i_dex_valid = 0; dif.i_dex_inst = ADD_432; dif.i_dex_ctrl = 16'hFFFF; dif.i_dex_rd_wren = 1;
    tick();
    n_vec++; if (dif.o_dex_valid !== 1'b0) begin n_err++; $display("FAIL inv_valid: got %b want 0", dif.o_dex_valid); end
    n_vec++; if (dif.o_dex_ctrl !== 16'h0) begin n_err++; $display("FAIL inv_ctrl: got %h want 0", dif.o_dex_ctrl); end
    n_vec++; if (dif.o_dex_rd_wren !== 1'b0) begin n_err++; $display("FAIL inv_rd_wren: got %b want 0", dif.o_dex_rd_wren); end
  endtask

  task automatic test_load_use();
    set_idle();
    dif.i_dex_valid = 1; dif.i_dex_pc = 32'h100; dif.i_dex_inst = LW_X5;
    dif.i_dex_is_load = 1; dif.i_dex_rd_wren = 1; dif.i_dex_uses_rs1 = 1;
    tick();
    dif.i_dex_pc = 32'h104; dif.i_dex_inst = ADD_655; dif.i_dex_is_load = 0;
    dif.i_dex_uses_rs1 = 1; dif.i_dex_uses_rs2 = 1; dif.i_dex_rs1_data = 32'h55;
    #1;
    n_vec++; if (dif.o_dex_load_use !== 1'b1) begin n_err++; $display("FAIL lu_detect: got %b want 1", dif.o_dex_load_use); end
    n_vec++; if (dif.o_dex_stall_up !== 1'b1) begin n_err++; $display("FAIL lu_stall_up: got %b want 1", dif.o_dex_stall_up); end
    tick();
    n_vec++; if (dif.o_dex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble_valid: got %b want 0", dif.o_dex_valid); end
    n_vec++; if (dif.o_dex_inst !== NOP) begin n_err++; $display("FAIL lu_bubble_inst: got %h want %h", dif.o_dex_inst, NOP); end
    n_vec++; if (dif.o_dex_stall_cnt !== 2'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", dif.o_dex_stall_cnt); end
    n_vec++; if (dif.o_dex_load_use !== 1'b0) begin n_err++; $display("FAIL lu_clear: got %b want 0", dif.o_dex_load_use); end
    tick();
    n_vec++; if (dif.o_dex_inst !== ADD_655) begin n_err++; $display("FAIL lu_replay_inst: got %h want %h", dif.o_dex_inst, ADD_655); end
    n_vec++; if (dif.o_dex_pc !== 32'h104) begin n_err++; $display("FAIL lu_replay_pc: got %h want 104", dif.o_dex_pc); end
    n_vec++; if (dif.o_dex_rs1_data !== 32'h55) begin n_err++; $display("FAIL lu_replay_rs1: got %h want 55", dif.o_dex_rs1_data); end
  endtask

  task automatic test_hold();
    set_idle();
    dif.i_dex_valid = 1; dif.i_dex_pc = 32'h80; dif.i_dex_inst = ADD_432; dif.i_dex_imm = 32'h7;
    dif.i_dex_ctrl = 16'h1234; dif.i_dex_rd_wren = 1; dif.i_dex_rs1_data = 32'h1111; dif.i_dex_rs2_data = 32'h2222;
    tick();
    for (int i = 0; i < 3; i++) begin
      dif.i_dex_hold = 1;
      dif.i_dex_pc = 32'h84 + 32'(i * 4); dif.i_dex_inst = ADD_655; dif.i_dex_imm = 32'(i + 9);
      dif.i_dex_ctrl = 16'hBEEF; dif.i_dex_rs1_data = 32'h9999;
      #1;
      n_vec++; if (dif.o_dex_stall_up !== 1'b1) begin n_err++; $display("FAIL hold_stall_up[%0d]: got %b want 1", i, dif.o_dex_stall_up); end
      tick();
      n_vec++;
      if (dif.o_dex_pc !== 32'h80 || dif.o_dex_inst !== ADD_432 || dif.o_dex_imm !== 32'h7 ||
          dif.o_dex_ctrl !== 16'h1234 || dif.o_dex_rs1_data !== 32'h1111 || dif.o_dex_valid !== 1'b1) begin
        n_err++;
        $display("FAIL hold_frozen[%0d]: got pc=%h inst=%h imm=%h ctrl=%h rs1=%h v=%b want pc=80 inst=%h imm=7 ctrl=1234 rs1=1111 v=1",
                 i, dif.o_dex_pc, dif.o_dex_inst, dif.o_dex_imm, dif.o_dex_ctrl, dif.o_dex_rs1_data, dif.o_dex_valid, ADD_432);
      end
    end
  endtask

  task automatic test_flush_vs_hold();
    dif.i_dex_hold = 1; dif.i_dex_flush = 1;
    tick();
    set_idle();
    n_vec++; if (dif.o_dex_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", dif.o_dex_valid); end
    n_vec++; if (dif.o_dex_inst !== NOP) begin n_err++; $display("FAIL flush_inst: got %h want %h", dif.o_dex_inst, NOP); end
    n_vec++; if (dif.o_dex_ctrl !== 16'h0) begin n_err++; $display("FAIL flush_ctrl: got %h want 0", dif.o_dex_ctrl); end
    n_vec++; if (dif.o_dex_flush_cnt !== 2'd1) begin n_err++; $display("FAIL flush_cnt: got %0d want 1", dif.o_dex_flush_cnt); end
    n_vec++; if (dif.o_dex_stall_cnt !== 2'd1) begin n_err++; $display("FAIL flush_stall_cnt: got %0d want 1", dif.o_dex_stall_cnt); end
  endtask

  task automatic test_saturation();
    int exp_cnt = 1;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      dif.i_dex_valid = 1; dif.i_dex_inst = LW_X5; dif.i_dex_is_load = 1; dif.i_dex_rd_wren = 1;
      tick();
      dif.i_dex_inst = ADD_655; dif.i_dex_is_load = 0; dif.i_dex_uses_rs1 = 1;
      tick();
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      n_vec++; if (dif.o_dex_stall_cnt !== 2'(exp_cnt)) begin n_err++; $display("FAIL sat_stall_cnt[%0d]: got %0d want %0d", i, dif.o_dex_stall_cnt, exp_cnt); end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_invalid_capture();
    test_load_use();
    test_hold();
    test_flush_vs_hold();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
